// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Optional feature: define ALU_EXEC_MUL_EN to decode ALUOp 11 / Funct 0000 as a bit-serial MUL.
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MUL, OP_ILL
    } op_e;

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

    state_e             state_q, state_d;
    op_e                dec_op, op_q;
    logic [WIDTH-1:0]   res_q, fast_res;
    logic [SHW:0]       cnt_q;
    logic               ill_q;
    logic [SHW-1:0]     shamt;

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mplier_q;
`endif

    assign shamt = b[SHW-1:0];

    always_comb begin
        dec_op = OP_ILL;
        case (ALUOp)
            2'b00: dec_op = (Funct[2:0] == 3'b001) ? OP_SLL : OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (Funct)
                    4'b0000: dec_op = OP_ADD;
                    4'b1000: dec_op = OP_SUB;
                    4'b0111: dec_op = OP_AND;
                    4'b0110: dec_op = OP_OR;
                    4'b0100: dec_op = OP_XOR;
                    4'b0001: dec_op = OP_SLL;
                    4'b0101: dec_op = OP_SRL;
                    4'b1101: dec_op = OP_SRA;
                    4'b0010: dec_op = OP_SLT;
                    default: dec_op = OP_ILL;
                endcase
            end
`ifdef ALU_EXEC_MUL_EN
            2'b11: dec_op = (Funct == 4'b0000) ? OP_MUL : OP_ILL;
`endif
            default: dec_op = OP_ILL;
        endcase
    end

    // Value loaded into the result register on acceptance; shifts start from a, MUL from 0.
    always_comb begin
        fast_res = '0;
        case (dec_op)
            OP_ADD:                 fast_res = a + b;
            OP_SUB:                 fast_res = a - b;
            OP_AND:                 fast_res = a & b;
            OP_OR:                  fast_res = a | b;
            OP_XOR:                 fast_res = a ^ b;
            OP_SLT:                 fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL, OP_SRA: fast_res = a;
            default:                fast_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (dec_op)
                        OP_SLL, OP_SRL, OP_SRA: state_d = (shamt == '0) ? DONE : SHIFT;
`ifdef ALU_EXEC_MUL_EN
                        OP_MUL:                 state_d = MUL;
`endif
                        default:                state_d = DONE;
                    endcase
                end
            end
            SHIFT: if (cnt_q == (SHW+1)'(1)) state_d = DONE;
`ifdef ALU_EXEC_MUL_EN
            MUL:   if (cnt_q == (SHW+1)'(1)) state_d = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            ill_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q  <= dec_op;
                    ill_q <= (dec_op == OP_ILL);
                    res_q <= fast_res;
                    cnt_q <= (dec_op == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, shamt};
`ifdef ALU_EXEC_MUL_EN
                    mcand_q  <= a;
                    mplier_q <= b;
`endif
                end
                SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // SRA: the MSB never changes, so it still equals the captured a[WIDTH-1].
                    case (op_q)
                        OP_SLL:  res_q <= {res_q[WIDTH-2:0], 1'b0};
                        OP_SRL:  res_q <= {1'b0, res_q[WIDTH-1:1]};
                        default: res_q <= {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                    endcase
                end
`ifdef ALU_EXEC_MUL_EN
                MUL: begin
                    cnt_q    <= cnt_q - 1'b1;
                    if (mplier_q[0]) res_q <= res_q + mcand_q;
                    mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                end
`endif
                default: ;
            endcase
        end
    end

    assign result  = res_q;
    assign zero    = (res_q == '0);
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=64), immediate assertions per check.
module tb_alu_exec_unit;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   ALUOp = '0;
    logic [3:0]   Funct = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_chk = 0;
    int n_fail = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, measure latency, check, hold, pop.
    task automatic run(input string tag, input logic [1:0] op, input logic [3:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] exp_r, input int exp_lat, input logic exp_ill,
                       input int hold);
        int lat;
        @(negedge clk);
        ALUOp = op; Funct = fn; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        ALUOp = 2'($urandom); Funct = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, W'(lat), W'(exp_lat));
        chk({tag, " result"}, result, exp_r);
        chk({tag, " zero"}, W'(zero), W'(exp_r == '0));
        chk({tag, " illegal"}, W'(illegal), W'(exp_ill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold result"}, result, exp_r);
            chk({tag, " hold out_valid"}, W'(out_valid), W'(1));
            chk({tag, " hold in_ready"}, W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " pop out_valid"}, W'(out_valid), W'(0));
        chk({tag, " pop in_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        #2;
        chk("rst in_ready", W'(in_ready), W'(1));
        chk("rst out_valid", W'(out_valid), W'(0));
        chk("rst result", result, '0);
        chk("rst zero", W'(zero), W'(1));
        chk("rst illegal", W'(illegal), W'(0));
        @(negedge clk); reset = 1'b0;

        run("sub", 2'b10, 4'b1000, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b0, 0);
        run("sra", 2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 5, 1'b0, 0);
        run("sll0", 2'b00, 4'b0001, 64'd1, 64'd0, 64'd1, 1, 1'b0, 3);
        run("undec", 2'b10, 4'b0011, 64'd9, 64'd9, 64'd0, 1, 1'b1, 0);
        run("and", 2'b10, 4'b0111, 64'hF0F0, 64'hFF00, 64'hF000, 1, 1'b0, 0);
        run("or", 2'b10, 4'b0110, 64'hF0F0, 64'h0F00, 64'hFFF0, 1, 1'b0, 0);
        run("xor", 2'b10, 4'b0100, 64'hFFFF, 64'h0F0F, 64'hF0F0, 1, 1'b0, 0);
        run("slt neg", 2'b10, 4'b0010, '1, 64'd1, 64'd1, 1, 1'b0, 0);
        run("slt pos", 2'b10, 4'b0010, 64'd1, '1, 64'd0, 1, 1'b0, 0);
        run("add wrap", 2'b10, 4'b0000, '1, 64'd1, 64'd0, 1, 1'b0, 0);
        run("srl", 2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd3, 64'h1000_0000_0000_0000, 4, 1'b0, 0);
        run("sll amt mask", 2'b10, 4'b0001, 64'd3, 64'h41, 64'd6, 2, 1'b0, 0);
        run("sll 63", 2'b10, 4'b0001, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 64, 1'b0, 0);
        run("sra pos", 2'b10, 4'b1101, 64'h4000_0000_0000_0000, 64'd2, 64'h1000_0000_0000_0000, 3, 1'b0, 0);
        run("aluop01 sub", 2'b01, 4'b1111, 64'd10, 64'd3, 64'd7, 1, 1'b0, 0);
        run("aluop00 add", 2'b00, 4'b0101, 64'd2, 64'd3, 64'd5, 1, 1'b0, 0);
        run("aluop00 sll", 2'b00, 4'b1001, 64'd1, 64'd2, 64'd4, 3, 1'b0, 0);

        // Reset in the middle of a long shift.
        @(negedge clk);
        ALUOp = 2'b10; Funct = 4'b0001; a = 64'd1; b = 64'd40; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midshift in_ready", W'(in_ready), W'(0));
        chk("midshift out_valid", W'(out_valid), W'(0));
        #2 reset = 1'b1;
        #1;
        chk("abort out_valid", W'(out_valid), W'(0));
        chk("abort in_ready", W'(in_ready), W'(1));
        chk("abort result", result, '0);
        @(negedge clk); reset = 1'b0;
        run("post-rst add", 2'b10, 4'b0000, 64'd2, 64'd3, 64'd5, 1, 1'b0, 0);

`ifdef ALU_EXEC_MUL_EN
        run("mul", 2'b11, 4'b0000, 64'd6, 64'd7, 64'd42, 65, 1'b0, 0);
`else
        run("mul undec", 2'b11, 4'b0000, 64'd6, 64'd7, 64'd0, 1, 1'b1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
